// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end: channel FSM encoding and
// default timing constants derived from the 1 kHz system clock.
package stopwatch_pkg;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned DEBOUNCE_MS = CLK_HZ / 50;
  localparam int unsigned LONG_MS     = CLK_HZ;
  localparam int unsigned REPEAT_MS   = CLK_HZ / 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce FSM, long-press timer.
// Optional auto-repeat of press_pulse when BTN_AUTO_REPEAT_EN is defined.
module button_channel #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_MS = stopwatch_pkg::DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = stopwatch_pkg::LONG_MS
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_MS   = stopwatch_pkg::REPEAT_MS
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  import stopwatch_pkg::*;

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_MS);
  localparam int unsigned HOLD_W = $clog2(LONG_MS);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  btn_state_e             state;
  logic [DB_W-1:0]        db_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   long_done;
  logic                   pressed;
  logic                   db_last;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_MS);
  logic [REP_W-1:0]       rep_cnt;
`endif

  assign s       = sync[SYNC_STAGES-1];
  assign pressed = (state == HELD) || (state == DB_RELEASE);
  assign db_last = (db_cnt == DB_W'(DEBOUNCE_MS - 1));

  // Release acceptance is handled last so it overrides long/repeat pulses on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= '0;
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], btn_raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      if (pressed && !long_done) begin
        if (hold_cnt == HOLD_W'(LONG_MS - 1)) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end

`ifdef BTN_AUTO_REPEAT_EN
      if (pressed && long_done) begin
        if (rep_cnt == REP_W'(REPEAT_MS - 1)) begin
          press_pulse <= 1'b1;
          rep_cnt     <= '0;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
`endif

      case (state)
        IDLE: begin
          if (s) begin
            state  <= DB_PRESS;
            db_cnt <= DB_W'(1);
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_last) begin
            state       <= HELD;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state  <= DB_RELEASE;
            db_cnt <= DB_W'(1);
          end
        end
        DB_RELEASE: begin
          if (s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_last) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            long_pulse    <= 1'b0;
            press_pulse   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt       <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw buttons into clean levels and press/release/long pulses.
// Define BTN_AUTO_REPEAT_EN to enable press_pulse auto-repeat while held.
module button_conditioner #(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_MS = stopwatch_pkg::DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = stopwatch_pkg::LONG_MS
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_MS   = stopwatch_pkg::REPEAT_MS
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);
  import stopwatch_pkg::*;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
`ifdef BTN_AUTO_REPEAT_EN
      ,
      .REPEAT_MS   (REPEAT_MS)
`endif
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised + directed bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

  localparam int NUM  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 20;
  localparam int LONG = 1000;
  localparam int REP  = 200;

  logic           clk = 1'b0;
  logic           rst;
  logic [NUM-1:0] btn_raw;
  logic [NUM-1:0] btn_level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int npress[NUM];
  int nrel[NUM];

  button_conditioner #(
    .NUM_BTN     (NUM),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_MS (DEB),
    .LONG_MS     (LONG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an input change is accepted once the synchronised value has
  // disagreed with the accepted level for DEB consecutive samples; timing pulses
  // are derived from the number of edges since press acceptance.
  logic [NUM-1:0] raw_log[$];
  logic [NUM-1:0] m_level;
  int             m_run[NUM];
  int             m_since[NUM];
  bit             m_valid = 1'b0;

  always @(negedge clk) begin
    logic [NUM-1:0] s_v, e_press, e_rel, e_long;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    if (rst) begin
      raw_log.delete();
      m_level = '0;
      for (int c = 0; c < NUM; c++) begin
        m_run[c]   = 0;
        m_since[c] = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      s_v = (raw_log.size() >= SYNC) ? raw_log[raw_log.size() - SYNC] : '0;
      raw_log.push_back(btn_raw);
      for (int c = 0; c < NUM; c++) begin
        if (s_v[c] != m_level[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_level[c]) m_since[c]++;
        if (m_run[c] == DEB) begin
          m_run[c]   = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            e_press[c] = 1'b1;
            m_since[c] = 0;
          end else begin
            e_rel[c] = 1'b1;
          end
        end else if (m_level[c]) begin
          if (m_since[c] == LONG) e_long[c] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          if (m_since[c] > LONG && (m_since[c] - LONG) % REP == 0) e_press[c] = 1'b1;
`endif
        end
      end
    end
    if (m_valid) begin
      check_eq("outputs", 32'({btn_level, press_pulse, release_pulse, long_pulse}),
               32'({m_level, e_press, e_rel, e_long}));
      for (int c = 0; c < NUM; c++) begin
        if (press_pulse[c]) npress[c]++;
        if (release_pulse[c]) nrel[c]++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 press, 1 release, 2 long. n = ticks until the bit is seen, 0 on timeout.
  task automatic wait_bit(input int kind, input int ch, input int max, output int n);
    logic [NUM-1:0] v;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      case (kind)
        0:       v = press_pulse;
        1:       v = release_pulse;
        default: v = long_pulse;
      endcase
      if (v[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    int rem[NUM];
    for (int c = 0; c < NUM; c++) begin
      npress[c] = 0;
      nrel[c]   = 0;
    end
    rst     = 1'b1;
    btn_raw = '0;
    repeat (3) tick();
    check_eq("reset_state", 32'({btn_level, press_pulse, release_pulse, long_pulse}), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // Clean press on btn0, then long press and release
    btn_raw[0] = 1'b1;
    wait_bit(0, 0, 100, n);
    check_eq("press_latency", 32'(n), 32'd22);
    check_eq("level_at_press", 32'(btn_level[0]), 32'd1);
    tick();
    check_eq("press_width", 32'(press_pulse[0]), 32'd0);
    wait_bit(2, 0, 1200, n);
    check_eq("long_latency", 32'(n + 1), 32'd1000);
    repeat (499) tick();
    btn_raw[0] = 1'b0;
    wait_bit(1, 0, 100, n);
    check_eq("release_latency", 32'(n), 32'd22);
    check_eq("level_after_rel", 32'(btn_level[0]), 32'd0);
    repeat (10) tick();

    // Bounce on btn1 shorter than the debounce window
    base = npress[1];
    btn_raw[1] = 1'b1; repeat (5) tick();
    btn_raw[1] = 1'b0; repeat (3) tick();
    btn_raw[1] = 1'b1; repeat (10) tick();
    btn_raw[1] = 1'b0; repeat (40) tick();
    check_eq("bounce_no_press", 32'(npress[1] - base), 32'd0);
    check_eq("bounce_level", 32'(btn_level[1]), 32'd0);

    // Simultaneous btn0/btn2 press, glitch on btn0 while held
    btn_raw = 4'b0101;
    wait_bit(0, 0, 100, n);
    check_eq("dual_latency", 32'(n), 32'd22);
    check_eq("dual_press_vec", 32'(press_pulse), 32'h5);
    base = nrel[0];
    repeat (300) tick();
    btn_raw[0] = 1'b0; repeat (3) tick();
    btn_raw[0] = 1'b1;
    wait_bit(2, 0, 1000, n);
    check_eq("long_after_glitch", 32'(303 + n), 32'd1000);
    check_eq("glitch_no_rel", 32'(nrel[0] - base), 32'd0);
    btn_raw = '0;
    wait_bit(1, 0, 100, n);
    check_eq("dual_rel_latency", 32'(n), 32'd22);
    check_eq("dual_rel_vec", 32'(release_pulse), 32'h5);
    repeat (10) tick();

    // Reset mid-debounce with btn3 still held
    btn_raw[3] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_eq("mid_reset_out", 32'({btn_level, press_pulse, release_pulse, long_pulse}), 32'd0);
    rst = 1'b0;
    wait_bit(0, 3, 100, n);
    check_eq("press_after_rst", 32'(n), 32'd22);
    base = npress[3];
`ifdef BTN_AUTO_REPEAT_EN
    wait_bit(0, 3, 1300, n);
    check_eq("repeat1", 32'(n), 32'd1200);
    wait_bit(0, 3, 300, n);
    check_eq("repeat2", 32'(n), 32'd200);
    wait_bit(0, 3, 300, n);
    check_eq("repeat3", 32'(n), 32'd200);
`else
    repeat (1600) tick();
    check_eq("no_repeat", 32'(npress[3] - base), 32'd0);
`endif
    btn_raw[3] = 1'b0;
    wait_bit(1, 3, 100, n);
    check_eq("rel_ch3", 32'(n), 32'd22);

    // Random segments: mostly short glitches, occasionally long holds
    for (int c = 0; c < NUM; c++) rem[c] = 0;
    for (int t = 0; t < 9000; t++) begin
      rst = (t >= 4500 && t < 4503);
      for (int c = 0; c < NUM; c++) begin
        if (rem[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 1300))
                                              : int'($urandom_range(1, 25));
        end else begin
          rem[c]--;
        end
      end
      tick();
    end
    rst = 1'b0;
    btn_raw = '0;
    repeat (50) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
